// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, behind a ready/valid interlock.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [5:0]      funct_in,
    input  logic [XLEN-1:0] rs_in,
    input  logic [XLEN-1:0] rt_in,
    input  logic            flush_in,
    output logic            ready_out,
    output logic            busy_out,
    output logic            done_out,
    output logic [XLEN-1:0] result_out,
    output logic            result_valid_out,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     count;
    logic [2*XLEN:0]   acc;       // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]   oper;      // multiplicand or divisor magnitude
    logic              op_div;
    logic              neg_q;
    logic              neg_r;

    logic              accept;
    logic              is_muldiv;
    logic              is_signed;
    logic              div_by_zero;
    logic              last_iter;
    logic [XLEN-1:0]   rs_mag;
    logic [XLEN-1:0]   rt_mag;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     trial;
    logic [2*XLEN:0]   shifted;
    logic [2*XLEN:0]   acc_next;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quotient;
    logic [XLEN-1:0]   remainder;

    // A flush in IDLE drops the request rather than racing it.
    assign accept      = valid_in & ready_out & ~flush_in;
    assign is_muldiv   = (funct_in == F_MULT) || (funct_in == F_MULTU) ||
                         (funct_in == F_DIV)  || (funct_in == F_DIVU);
    assign is_signed   = ~funct_in[0];
    assign div_by_zero = funct_in[1] && (rt_in == '0);
    assign last_iter   = (count == LAST_ITER);
    assign rs_mag      = (is_signed && rs_in[XLEN-1]) ? -rs_in : rs_in;
    assign rt_mag      = (is_signed && rt_in[XLEN-1]) ? -rt_in : rt_in;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, oper} : '0);
        shifted  = acc << 1;
        trial    = shifted[2*XLEN:XLEN] - {1'b0, oper};
        acc_next = {add_sum, acc[XLEN-1:0]} >> 1;
        if (op_div) begin
            acc_next = trial[XLEN] ? shifted : {trial, shifted[XLEN-1:1], 1'b1};
        end
        product   = neg_q ? -acc_next[2*XLEN-1:0] : acc_next[2*XLEN-1:0];
        quotient  = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        remainder = neg_r ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && is_muldiv) state_next = div_by_zero ? DONE : RUN;
            RUN: begin
                if (flush_in)       state_next = IDLE;
                else if (last_iter) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_out = (state == IDLE);
        busy_out  = (state != IDLE);
        done_out  = (state == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_out           <= '0;
            lo_out           <= '0;
            result_out       <= '0;
            result_valid_out <= 1'b0;
            acc              <= '0;
            oper             <= '0;
            count            <= '0;
            op_div           <= 1'b0;
            neg_q            <= 1'b0;
            neg_r            <= 1'b0;
        end else begin
            result_valid_out <= 1'b0;
            if (state == IDLE && accept) begin
                case (funct_in)
                    F_MTHI: hi_out <= rs_in;
                    F_MTLO: lo_out <= rs_in;
                    F_MFHI: begin
                        result_out       <= hi_out;
                        result_valid_out <= 1'b1;
                    end
                    F_MFLO: begin
                        result_out       <= lo_out;
                        result_valid_out <= 1'b1;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        if (div_by_zero) begin
                            hi_out <= rs_in;
                            lo_out <= '1;
                        end else begin
                            op_div <= funct_in[1];
                            neg_q  <= is_signed & (rs_in[XLEN-1] ^ rt_in[XLEN-1]);
                            neg_r  <= is_signed & rs_in[XLEN-1];
                            oper   <= funct_in[1] ? rt_mag : rs_mag;
                            acc    <= {{(XLEN+1){1'b0}}, (funct_in[1] ? rs_mag : rt_mag)};
                            count  <= '0;
                        end
                    end
                    default: ;
                endcase
            end else if (state == RUN && !flush_in) begin
                acc   <= acc_next;
                count <= count + 1'b1;
                if (last_iter) begin
                    if (op_div) begin
                        hi_out <= remainder;
                        lo_out <= quotient;
                    end else begin
                        hi_out <= product[2*XLEN-1:XLEN];
                        lo_out <= product[XLEN-1:0];
                    end
                end
            end
        end
    end

endmodule
